// File: rtl/spi_flash_line_fetch.sv
// SPI flash READ master: sends CMD + 24-bit address, then streams a
// programmable number of bytes back as one-cycle byte_valid strobes.
module spi_flash_line_fetch #(
  parameter logic [7:0]  CMD   = 8'h03,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  localparam int unsigned CNT_W = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_END
  } state_t;

  state_t           r_state;
  logic [31:0]      r_tx;
  logic [4:0]       r_tx_cnt;
  logic [6:0]       r_rx;
  logic [2:0]       r_bit_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_byte_data;
  logic             r_byte_valid;
  logic             r_cs;
  logic             r_sclk;
  logic             r_mosi;

  logic [CNT_W-1:0] w_len_eff;
  logic             w_last_byte;

  // len of zero selects the full 2^LEN_W byte count
  assign w_len_eff   = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};
  assign w_last_byte = (r_byte_cnt == r_len);

  assign busy       = r_busy;
  assign done       = r_done;
  assign byte_data  = r_byte_data;
  assign byte_valid = r_byte_valid;
  assign spi_cs     = r_cs;
  assign spi_sclk   = r_sclk;
  assign spi_mosi   = r_mosi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_tx         <= '0;
      r_tx_cnt     <= '0;
      r_rx         <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_len        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_cs         <= 1'b0;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_byte_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_CMD;
            r_cs       <= 1'b1;
            r_busy     <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= CMD[7];
            r_tx       <= {CMD[6:0], addr, 1'b0};
            r_tx_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_len      <= w_len_eff;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_cs    <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!r_sclk) begin
            // rising SCLK: sample MISO during the data phase
            r_sclk <= 1'b1;
            if (r_state == S_DATA) begin
              r_rx      <= {r_rx[5:0], spi_miso};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_byte_data  <= {r_rx, spi_miso};
                r_byte_valid <= 1'b1;
                r_byte_cnt   <= r_byte_cnt + CNT_W'(1);
              end
            end
          end else begin
            // falling SCLK: advance MOSI or finish after the last data bit
            r_sclk <= 1'b0;
            if (r_state == S_DATA) begin
              if (w_last_byte) begin
                r_state <= S_END;
                r_cs    <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_tx_cnt <= r_tx_cnt + 5'd1;
              r_tx     <= {r_tx[30:0], 1'b0};
              r_mosi   <= r_tx[31];
              if (r_tx_cnt == 5'd7) begin
                r_state <= S_ADDR;
              end
              if (r_tx_cnt == 5'd31) begin
                r_state <= S_DATA;
                r_mosi  <= 1'b0;
              end
            end
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_cs    <= 1'b0;
          r_sclk  <= 1'b0;
        end
      endcase
    end
  end

endmodule
